// File: rtl/pid_motor_scheduler.sv
// Sequences one X/Y control update: launch both PID units, collect results, then drive X and Y motor commands.
// Optional build macro PID_SCHED_CLAMP_EN saturates captured PID results to +/-MOTOR_LIMIT.
module pid_motor_scheduler #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned MOTOR_LIMIT    = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     x_pid_ready,
  input  logic                     y_pid_ready,
  input  logic signed [DATA_W-1:0] x_pid_out,
  input  logic signed [DATA_W-1:0] y_pid_out,
  input  logic                     motor_ready,
  output logic                     x_pid_en,
  output logic                     y_pid_en,
  output logic                     motor_driver,
  output logic                     motor_axis,
  output logic signed [DATA_W-1:0] motor_cmd,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err
);

  localparam int unsigned CLOG_T  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned WD_W    = (CLOG_T > 16) ? CLOG_T : 16;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 2 || 64'(MOTOR_LIMIT) >= (64'd1 << (DATA_W - 1))) begin : g_param_check
    $error("pid_motor_scheduler: TIMEOUT_CYCLES must be >= 2 and MOTOR_LIMIT must fit DATA_W");
  end

`ifdef PID_SCHED_CLAMP_EN
  localparam logic signed [DATA_W-1:0] LIM_POS = DATA_W'(MOTOR_LIMIT);
  localparam logic signed [DATA_W-1:0] LIM_NEG = -LIM_POS;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W-1:0] v);
    if (v > LIM_POS) return LIM_POS;
    if (v < LIM_NEG) return LIM_NEG;
    return v;
  endfunction
`else
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W-1:0] v);
    return v;
  endfunction
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_PID, S_MOTOR_X, S_MOTOR_Y, S_DONE
  } state_t;

  state_t                     state, state_nx;
  logic                       x_flag, y_flag, x_flag_nx, y_flag_nx;
  logic signed [DATA_W-1:0]   x_cap, y_cap, x_cap_nx, y_cap_nx;
  logic [WD_W-1:0]            wdog;
  logic                       waiting, wd_hit, pid_both, motor_ack;
  logic                       x_pid_en_d, y_pid_en_d, motor_driver_d, motor_axis_d;
  logic                       busy_d, done_d, timeout_err_d;
  logic signed [DATA_W-1:0]   motor_cmd_d;

  // Motor handshake only counts while a command is actually presented (skips the inter-axis gap).
  assign motor_ack = motor_ready && motor_driver;
  assign pid_both  = (x_flag || x_pid_ready) && (y_flag || y_pid_ready);
  assign waiting   = (state == S_WAIT_PID) || (state == S_MOTOR_X) || (state == S_MOTOR_Y);
  assign wd_hit    = waiting && (wdog == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = S_LAUNCH;
      S_LAUNCH:   state_nx = S_WAIT_PID;
      S_WAIT_PID: if (pid_both) state_nx = S_MOTOR_X;
                  else if (wd_hit) state_nx = S_DONE;
      S_MOTOR_X:  if (motor_ack) state_nx = S_MOTOR_Y;
                  else if (wd_hit) state_nx = S_DONE;
      S_MOTOR_Y:  if (motor_ack || wd_hit) state_nx = S_DONE;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Next values of captured results/flags; used directly so a same-cycle capture reaches motor_cmd.
  always_comb begin
    x_cap_nx  = x_cap;
    y_cap_nx  = y_cap;
    x_flag_nx = x_flag;
    y_flag_nx = y_flag;
    if (state == S_IDLE && start) begin
      x_flag_nx = 1'b0;
      y_flag_nx = 1'b0;
    end else if (state == S_WAIT_PID) begin
      if (x_pid_ready) begin
        x_flag_nx = 1'b1;
        x_cap_nx  = sat(x_pid_out);
      end
      if (y_pid_ready) begin
        y_flag_nx = 1'b1;
        y_cap_nx  = sat(y_pid_out);
      end
    end
  end

  always_comb begin
    x_pid_en_d     = (state_nx == S_LAUNCH);
    y_pid_en_d     = (state_nx == S_LAUNCH);
    motor_driver_d = (state_nx == S_MOTOR_X) || (state_nx == S_MOTOR_Y && state == S_MOTOR_Y);
    motor_axis_d   = (state_nx == S_MOTOR_Y);
    motor_cmd_d    = '0;
    if (state_nx == S_MOTOR_X) motor_cmd_d = x_cap_nx;
    if (state_nx == S_MOTOR_Y) motor_cmd_d = y_cap_nx;
    busy_d         = (state_nx != S_IDLE);
    done_d         = (state_nx == S_DONE);
    timeout_err_d  = timeout_err;
    if (state == S_IDLE && start) timeout_err_d = 1'b0;
    else if (wd_hit && state_nx == S_DONE && !motor_ack) timeout_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_pid_en     <= 1'b0;
      y_pid_en     <= 1'b0;
      motor_driver <= 1'b0;
      motor_axis   <= 1'b0;
      motor_cmd    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      x_cap        <= '0;
      y_cap        <= '0;
      x_flag       <= 1'b0;
      y_flag       <= 1'b0;
      wdog         <= '0;
    end else begin
      x_pid_en     <= x_pid_en_d;
      y_pid_en     <= y_pid_en_d;
      motor_driver <= motor_driver_d;
      motor_axis   <= motor_axis_d;
      motor_cmd    <= motor_cmd_d;
      busy         <= busy_d;
      done         <= done_d;
      timeout_err  <= timeout_err_d;
      x_cap        <= x_cap_nx;
      y_cap        <= y_cap_nx;
      x_flag       <= x_flag_nx;
      y_flag       <= y_flag_nx;
      if (state_nx != state) wdog <= '0;
      else if (waiting)      wdog <= wdog + 1'b1;
    end
  end

endmodule

// File: tb/tb_pid_motor_scheduler.sv
// Directed bench for pid_motor_scheduler: table of full updates plus reset, timeout and restart sequences.
module tb_pid_motor_scheduler;

`ifdef PID_SCHED_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic clk, reset, start, x_pid_ready, y_pid_ready, motor_ready;
  logic [15:0] x_pid_out, y_pid_out;
  logic x_pid_en, y_pid_en, motor_driver, motor_axis, busy, done, timeout_err;
  logic [15:0] motor_cmd;
  logic t_x_pid_en, t_y_pid_en, t_motor_driver, t_motor_axis, t_busy, t_done, t_timeout_err;
  logic [15:0] t_motor_cmd;

  int checks = 0;
  int errors = 0;

  pid_motor_scheduler #(.DATA_W(16), .TIMEOUT_CYCLES(64), .MOTOR_LIMIT(1000)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x_pid_ready(x_pid_ready), .y_pid_ready(y_pid_ready),
    .x_pid_out(x_pid_out), .y_pid_out(y_pid_out), .motor_ready(motor_ready),
    .x_pid_en(x_pid_en), .y_pid_en(y_pid_en), .motor_driver(motor_driver),
    .motor_axis(motor_axis), .motor_cmd(motor_cmd), .busy(busy), .done(done),
    .timeout_err(timeout_err));

  pid_motor_scheduler #(.DATA_W(16), .TIMEOUT_CYCLES(8), .MOTOR_LIMIT(1000)) dut_to (
    .clk(clk), .reset(reset), .start(start),
    .x_pid_ready(x_pid_ready), .y_pid_ready(y_pid_ready),
    .x_pid_out(x_pid_out), .y_pid_out(y_pid_out), .motor_ready(motor_ready),
    .x_pid_en(t_x_pid_en), .y_pid_en(t_y_pid_en), .motor_driver(t_motor_driver),
    .motor_axis(t_motor_axis), .motor_cmd(t_motor_cmd), .busy(t_busy), .done(t_done),
    .timeout_err(t_timeout_err));

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; int xd; int yd; bit early; bit restart; int ex; int ey;
  } vec_t;

  vec_t tbl[5];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; x_pid_ready = 0; y_pid_ready = 0; motor_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; step(); step(); reset = 0;
  endtask

  // One full update against the main instance; bench plays both PID units and the motor driver.
  task automatic run_txn(input vec_t v, input string tag);
    int cyc = 1, rises = 0, drv_cnt = 0, fall_cyc = -1, done_cyc = -1, dones = 0, busy_at_done = 0;
    int rise_cyc[2], cmd[2], axis[2];
    int mx = (v.xd > v.yd) ? v.xd : v.yd;
    start = 1; step(); start = 0;
    chk({tag, " pid_en"}, int'({x_pid_en, y_pid_en}), 3);
    while (cyc < 200 && done_cyc < 0) begin
      if (motor_driver) begin
        drv_cnt++;
        if (drv_cnt == 1 && rises < 2) begin
          rise_cyc[rises] = cyc; cmd[rises] = int'($signed(motor_cmd)); axis[rises] = int'(motor_axis);
          rises++;
        end
      end else begin
        if (drv_cnt > 0 && fall_cyc < 0) fall_cyc = cyc;
        drv_cnt = 0;
      end
      if (cyc == 2) chk({tag, " pid_en_pulse"}, int'({x_pid_en, y_pid_en}), 0);
      if (done) begin done_cyc = cyc; dones++; busy_at_done = int'(busy); end
      x_pid_ready = (cyc == 1 + v.xd) || (v.early && cyc == 1);
      y_pid_ready = (cyc == 1 + v.yd) || (v.early && cyc == 1);
      x_pid_out   = (v.early && cyc == 1) ? 16'h5A5A : 16'(v.x);
      y_pid_out   = (v.early && cyc == 1) ? 16'hA5A5 : 16'(v.y);
      motor_ready = motor_driver && drv_cnt == 2;
      start       = v.restart && (cyc == 4 || cyc == done_cyc);
      step(); cyc++;
    end
    idle_inputs();
    if (done_cyc < 0) chk({tag, " done_seen"}, 0, 1);
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      step();
    end
    chk({tag, " rises"}, rises, 2);
    chk({tag, " x_rise_cyc"}, rise_cyc[0], 2 + mx);
    chk({tag, " x_cmd"}, cmd[0], v.ex);
    chk({tag, " x_axis"}, axis[0], 0);
    chk({tag, " y_cmd"}, cmd[1], v.ey);
    chk({tag, " y_axis"}, axis[1], 1);
    chk({tag, " gap"}, rise_cyc[1] - fall_cyc, 1);
    chk({tag, " done_cyc"}, done_cyc, 7 + mx);
    chk({tag, " busy_at_done"}, busy_at_done, 1);
    chk({tag, " done_count"}, dones, 1);
    chk({tag, " idle_busy"}, int'(busy), 0);
    chk({tag, " timeout_err"}, int'(timeout_err), 0);
  endtask

  initial begin
    int cyc, hi_cnt, done_cyc, err_at_done, drv_at_done;
    clk = 0; reset = 1; x_pid_out = 0; y_pid_out = 0;
    idle_inputs();

    tbl[0] = '{x: 100,    y: -50,   xd: 1,  yd: 1, early: 0, restart: 0, ex: 100,  ey: -50};
    tbl[1] = '{x: 1234,   y: -777,  xd: 10, yd: 3, early: 0, restart: 0, ex: 1234, ey: -777};
    tbl[2] = '{x: 3000,   y: -4000, xd: 1,  yd: 1, early: 0, restart: 0,
               ex: CLAMP ? 1000 : 3000, ey: CLAMP ? -1000 : -4000};
    tbl[3] = '{x: -32768, y: 32767, xd: 3,  yd: 4, early: 1, restart: 0,
               ex: CLAMP ? -1000 : -32768, ey: CLAMP ? 1000 : 32767};
    tbl[4] = '{x: -5,     y: 7,     xd: 2,  yd: 2, early: 0, restart: 1, ex: -5,   ey: 7};

    step(); step(); step();
    chk("reset_outs", int'({x_pid_en, y_pid_en, motor_driver, motor_axis, busy, done, timeout_err}), 0);
    chk("reset_cmd", int'(motor_cmd), 0);
    chk("reset_outs_to", int'({t_x_pid_en, t_y_pid_en, t_motor_driver, t_busy, t_done, t_timeout_err}), 0);
    reset = 0; step();

    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Watchdog on the short-timeout instance: motor never answers.
    do_reset();
    start = 1; step(); start = 0;
    cyc = 1; hi_cnt = 0; done_cyc = -1; err_at_done = 0; drv_at_done = 1;
    x_pid_out = 16'(42); y_pid_out = 16'(-42);
    while (cyc < 60 && done_cyc < 0) begin
      if (t_motor_driver) hi_cnt++;
      if (t_done) begin done_cyc = cyc; err_at_done = int'(t_timeout_err); drv_at_done = int'(t_motor_driver); end
      x_pid_ready = (cyc == 2);
      y_pid_ready = (cyc == 2);
      step(); cyc++;
    end
    idle_inputs();
    chk("to_driver_cycles", hi_cnt, 8);
    chk("to_done_cyc", done_cyc, 11);
    chk("to_err_at_done", err_at_done, 1);
    chk("to_driver_dropped", drv_at_done, 0);
    step(); step(); step();
    chk("to_err_sticky", int'(t_timeout_err), 1);
    chk("to_busy_idle", int'(t_busy), 0);
    start = 1; step(); start = 0;
    chk("to_err_cleared", int'(t_timeout_err), 0);

    // Reset during MOTOR_X, then a clean update.
    do_reset();
    start = 1; step(); start = 0;
    cyc = 1;
    x_pid_out = 16'(55); y_pid_out = 16'(66);
    while (cyc < 20 && !motor_driver) begin
      x_pid_ready = (cyc == 1 + 1);
      y_pid_ready = (cyc == 1 + 1);
      step(); cyc++;
    end
    idle_inputs();
    chk("mid_in_motor_x", int'({motor_driver, motor_axis}), 2);
    chk("mid_cmd_before", int'($signed(motor_cmd)), 55);
    reset = 1; step();
    chk("mid_reset_outs", int'({x_pid_en, y_pid_en, motor_driver, motor_axis, busy, done, timeout_err}), 0);
    chk("mid_reset_cmd", int'(motor_cmd), 0);
    reset = 0; step();
    run_txn('{x: 5, y: -6, xd: 1, yd: 2, early: 0, restart: 0, ex: 5, ey: -6}, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
